// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video pattern generator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package video_timing_pkg;

    // pattern_sel encodings
    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_GRADIENT = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_SOLID    = 2'd3
    } pattern_e;

    // Generator FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    // Colour bar palette, {r,g,b}
    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    // Total clocks per line or lines per frame from the region sizes.
    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Bar index (left to right) to colour.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster h/v counters with region decode, frame wrap flag and colour-bar index.
// Latency: region flags are combinational from the current counter state.
// Backpressure: none; counters advance every cycle while en is high, hold otherwise.
// Ports: clk/reset (sync, active-high), en advances the raster; h/v current
// position; bar_idx current colour-bar; h_active/v_active/h_sync/v_sync region
// flags; frame_end high on the last count of the frame.
module video_timing_counter
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] h,
    output logic [15:0] v,
    output logic [2:0]  bar_idx,
    output logic        h_active,
    output logic        v_active,
    output logic        h_sync,
    output logic        v_sync,
    output logic        frame_end
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT_END  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT_END  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END     = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END     = 16'(V_ACTIVE + V_FP + V_SYNC);

    // Bars are tracked by a width counter plus index so no divider is needed.
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BCW   = $clog2(BAR_W + 1);
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

    logic [BCW-1:0] bar_cnt;
    logic           line_end;

    assign line_end  = (h == H_LAST);
    assign frame_end = line_end && (v == V_LAST);

    assign h_active  = (h < H_ACT_END);
    assign v_active  = (v < V_ACT_END);
    assign h_sync    = (h >= HS_START) && (h < HS_END);
    assign v_sync    = (v >= VS_START) && (v < VS_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            h       <= '0;
            v       <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (en) begin
            if (line_end) begin
                h       <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
                v       <= (v == V_LAST) ? '0 : v + 16'd1;
            end else begin
                h <= h + 16'd1;
                // Index runs past bar 7 into blanking; harmless since de is low there.
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + BCW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Video source: programmable raster timing plus selectable test pattern (vs/hs/de/RGB).
// Latency: counter state (h,v) appears on all outputs exactly one cycle later.
// Backpressure: none; free-running source, run=0 finishes the current frame then idles.
// Ports: clk/reset (sync, active-high); run; pattern_sel and solid_rgb sampled at
// frame start; vs_out/hs_out (SYNC_POL), de_out, r/g/b_out; frame_start pulse;
// busy while RUN/STOPPING; frame_count of completed frames.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        vs_out,
    output logic        hs_out,
    output logic        de_out,
    output logic [7:0]  r_out,
    output logic [7:0]  g_out,
    output logic [7:0]  b_out,
    output logic        frame_start,
    output logic        busy,
    output logic [15:0] frame_count
);

    state_e      state, state_nxt;
    logic        cnt_en, busy_nxt, frame_bound, de_nxt;
    logic [15:0] h, v;
    logic [2:0]  bar_idx;
    logic        h_active, v_active, h_sync, v_sync, frame_end;
    pattern_e    pat_q, pat_cur;
    logic [23:0] solid_q, solid_cur, rgb_nxt;

    video_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk      (clk),
        .reset    (reset),
        .en       (cnt_en),
        .h        (h),
        .v        (v),
        .bar_idx  (bar_idx),
        .h_active (h_active),
        .v_active (v_active),
        .h_sync   (h_sync),
        .v_sync   (v_sync),
        .frame_end(frame_end)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; stopping always lands on the frame wrap so counters are back at 0,0.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (run) state_nxt = ST_RUN;
            ST_RUN:      if (!run) state_nxt = frame_end ? ST_IDLE : ST_STOPPING;
            ST_STOPPING: begin
                if (run)            state_nxt = ST_RUN;
                else if (frame_end) state_nxt = ST_IDLE;
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cnt_en      = (state != ST_IDLE);
        busy_nxt    = (state_nxt != ST_IDLE);
        frame_bound = (state == ST_RUN) && (h == 16'd0) && (v == 16'd0);
    end

    // The first pixel of a frame already uses the newly sampled pattern settings.
    assign pat_cur   = frame_bound ? pattern_e'(pattern_sel) : pat_q;
    assign solid_cur = frame_bound ? solid_rgb : solid_q;
    assign de_nxt    = cnt_en && h_active && v_active;

    always_comb begin
        rgb_nxt = '0;
        case (pat_cur)
            PAT_BARS:     rgb_nxt = bar_colour(bar_idx);
            PAT_GRADIENT: rgb_nxt = {3{h[7:0]}};
            PAT_CHECKER:  rgb_nxt = (h[4] ^ v[4]) ? COL_WHITE : COL_BLACK;
            PAT_SOLID:    rgb_nxt = solid_cur;
            default:      rgb_nxt = '0;
        endcase
        if (!de_nxt) rgb_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            de_out      <= 1'b0;
            hs_out      <= ~SYNC_POL;
            vs_out      <= ~SYNC_POL;
            r_out       <= '0;
            g_out       <= '0;
            b_out       <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            pat_q       <= PAT_BARS;
            solid_q     <= '0;
        end else begin
            de_out                <= de_nxt;
            hs_out                <= (cnt_en && h_sync) ? SYNC_POL : ~SYNC_POL;
            vs_out                <= (cnt_en && v_sync) ? SYNC_POL : ~SYNC_POL;
            {r_out, g_out, b_out} <= rgb_nxt;
            frame_start           <= frame_bound;
            busy                  <= busy_nxt;
            if (cnt_en && frame_end) frame_count <= frame_count + 16'd1;
            if (frame_bound) begin
                pat_q   <= pat_cur;
                solid_q <= solid_cur;
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: small raster timing, patterns, run/stop, reset.
// Latency: expects each pixel one cycle after the counter reaches it.
// Backpressure: n/a.
module tb_video_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, run_a, run_b;
    logic [1:0]  psel_a, psel_b;
    logic [23:0] solid_a, solid_b;
    logic        vs_a, hs_a, de_a, fs_a, busy_a;
    logic        vs_b, hs_b, de_b, fs_b, busy_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic [15:0] fc_a, fc_b;

    int vectors     = 0;
    int miscompares = 0;
    logic [23:0] bar_tab [8];

    // A: H 16/2/2/2 (22 clocks), V 4/1/1/1 (7 lines), active-high syncs
    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .run(run_a), .pattern_sel(psel_a), .solid_rgb(solid_a),
        .vs_out(vs_a), .hs_out(hs_a), .de_out(de_a), .r_out(r_a), .g_out(g_a), .b_out(b_a),
        .frame_start(fs_a), .busy(busy_a), .frame_count(fc_a)
    );

    // B: H 32/2/2/2 (38 clocks), V 4/1/1/1 (7 lines), active-low syncs
    video_pattern_gen #(
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .run(run_b), .pattern_sel(psel_b), .solid_rgb(solid_b),
        .vs_out(vs_b), .hs_out(hs_b), .de_out(de_b), .r_out(r_b), .g_out(g_b), .b_out(b_b),
        .frame_start(fs_b), .busy(busy_b), .frame_count(fc_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps one 154-clock frame of DUT A (first sample = pixel 0) and checks it.
    // act: 1 switch to solid 123456, 2 switch to gradient, 3 drop run,
    //      4 drop run then restore it 30 clocks later.
    task automatic check_frame(input string name, input int pat, input logic [23:0] solid,
                               input int act, input int act_at, input int exp_busy_lo);
        int de_cnt = 0, hs_cnt = 0, hs_first = -1, vs_cnt = 0, vs_first = -1;
        int fs_cnt = 0, bad_px = 0, busy_lo = 0, fs0 = 0;
        for (int n = 0; n < 154; n++) begin
            int h, v;
            logic exp_de;
            logic [23:0] exp_rgb;
            step();
            h = n % 22;
            v = n / 22;
            exp_de = (h < 16) && (v < 4);
            exp_rgb = '0;
            if (exp_de) begin
                case (pat)
                    0:       exp_rgb = bar_tab[h / 2];
                    1:       exp_rgb = {3{8'(h)}};
                    default: exp_rgb = solid;
                endcase
            end
            if (de_a) de_cnt++;
            if (de_a !== exp_de || {r_a, g_a, b_a} !== exp_rgb) bad_px++;
            if (hs_a) begin hs_cnt++; if (hs_first < 0) hs_first = n; end
            if (vs_a) begin vs_cnt++; if (vs_first < 0) vs_first = n; end
            if (fs_a) begin fs_cnt++; if (n == 0) fs0 = 1; end
            if (!busy_a) busy_lo++;
            if (n == act_at) begin
                case (act)
                    1: begin psel_a = 2'd3; solid_a = 24'h123456; end
                    2: psel_a = 2'd1;
                    3, 4: run_a = 1'b0;
                    default: ;
                endcase
            end
            if (act == 4 && n == act_at + 30) run_a = 1'b1;
        end
        chk({name, ".de_cycles"}, de_cnt, 64);
        chk({name, ".pixels_bad"}, bad_px, 0);
        chk({name, ".hs_first"}, hs_first, 18);
        chk({name, ".hs_cycles"}, hs_cnt, 14);
        chk({name, ".vs_first"}, vs_first, 110);
        chk({name, ".vs_cycles"}, vs_cnt, 22);
        chk({name, ".fs_count"}, fs_cnt, 1);
        chk({name, ".fs_at_px0"}, fs0, 1);
        chk({name, ".busy_low"}, busy_lo, exp_busy_lo);
    endtask

    initial begin
        bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        reset = 1'b1; run_a = 1'b0; run_b = 1'b0;
        psel_a = 2'd0; psel_b = 2'd2; solid_a = '0; solid_b = 24'hABCDEF;
        step(); step();

        // Reset state, both polarities
        chk("rst.de_a", 32'(de_a), 0);
        chk("rst.hs_a", 32'(hs_a), 0);
        chk("rst.vs_a", 32'(vs_a), 0);
        chk("rst.hs_b", 32'(hs_b), 1);
        chk("rst.vs_b", 32'(vs_b), 1);
        chk("rst.rgb_a", 32'({r_a, g_a, b_a}), 0);
        chk("rst.fs_a", 32'(fs_a), 0);
        chk("rst.busy_a", 32'(busy_a), 0);
        chk("rst.fc_a", 32'(fc_a), 0);

        reset = 1'b0;
        step(); step();
        chk("idle.de_a", 32'(de_a), 0);
        chk("idle.busy_a", 32'(busy_a), 0);

        // run sampled: busy next cycle, first pixel one cycle after that
        run_a = 1'b1;
        step();
        chk("start.busy_a", 32'(busy_a), 1);
        chk("start.de_a", 32'(de_a), 0);

        check_frame("f1_bars", 0, 24'h0, 1, 50, 0);
        chk("f1.fc", 32'(fc_a), 1);
        check_frame("f2_solid", 3, 24'h123456, 2, 60, 0);
        chk("f2.fc", 32'(fc_a), 2);
        check_frame("f3_grad", 1, 24'h0, 4, 60, 0);
        chk("f3.fc", 32'(fc_a), 3);
        check_frame("f4_grad_stop", 1, 24'h0, 3, 100, 1);
        chk("f4.fc", 32'(fc_a), 4);

        step();
        chk("stopped.de_a", 32'(de_a), 0);
        chk("stopped.hs_a", 32'(hs_a), 0);
        chk("stopped.vs_a", 32'(vs_a), 0);
        chk("stopped.rgb_a", 32'({r_a, g_a, b_a}), 0);
        chk("stopped.fs_a", 32'(fs_a), 0);
        chk("stopped.busy_a", 32'(busy_a), 0);
        repeat (5) step();
        chk("stopped.fc_hold", 32'(fc_a), 4);
        chk("stopped.de_hold", 32'(de_a), 0);

        // Restart, then reset in the middle of line 1 of the following frame
        psel_a = 2'd0;
        run_a = 1'b1;
        step();
        check_frame("f5_bars", 0, 24'h0, 0, -1, 0);
        chk("f5.fc", 32'(fc_a), 5);
        repeat (30) step();
        chk("midline.de_a", 32'(de_a), 1);
        reset = 1'b1;
        step();
        chk("midrst.de_a", 32'(de_a), 0);
        chk("midrst.busy_a", 32'(busy_a), 0);
        chk("midrst.fc_a", 32'(fc_a), 0);
        chk("midrst.rgb_a", 32'({r_a, g_a, b_a}), 0);
        chk("midrst.hs_a", 32'(hs_a), 0);
        reset = 1'b0;
        step();
        check_frame("f6_after_rst", 0, 24'h0, 0, -1, 0);
        chk("f6.fc", 32'(fc_a), 1);
        run_a = 1'b0;

        // DUT B: checker pattern and active-low syncs
        run_b = 1'b1;
        step();
        for (int n = 0; n < 266; n++) begin
            step();
            case (n)
                0: begin
                    chk("b.px0_de", 32'(de_b), 1);
                    chk("b.px0_rgb", 32'({r_b, g_b, b_b}), 32'h000000);
                    chk("b.px0_fs", 32'(fs_b), 1);
                    chk("b.px0_busy", 32'(busy_b), 1);
                    chk("b.px0_hs", 32'(hs_b), 1);
                end
                15:  chk("b.px15_rgb", 32'({r_b, g_b, b_b}), 32'h000000);
                16:  chk("b.px16_rgb", 32'({r_b, g_b, b_b}), 32'hFFFFFF);
                31:  chk("b.px31_rgb", 32'({r_b, g_b, b_b}), 32'hFFFFFF);
                32:  chk("b.px32_de", 32'(de_b), 0);
                33:  chk("b.h33_hs", 32'(hs_b), 1);
                34:  chk("b.h34_hs", 32'(hs_b), 0);
                35:  chk("b.h35_hs", 32'(hs_b), 0);
                36:  chk("b.h36_hs", 32'(hs_b), 1);
                189: chk("b.v4_vs", 32'(vs_b), 1);
                190: chk("b.v5_vs", 32'(vs_b), 0);
                227: chk("b.v5end_vs", 32'(vs_b), 0);
                228: chk("b.v6_vs", 32'(vs_b), 1);
                default: ;
            endcase
        end
        chk("b.fc", 32'(fc_b), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
